// File: rtl/sram_arb2_ctrl_if.sv
// Bus bundle for sram_arb2_ctrl: two valid/ready requester ports plus the SRAM wrapper pins.
// slave = arbiter side, master = fabric/SRAM side.
interface sram_arb2_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          r0_valid;
    logic          r0_ready;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic [DW-1:0] r0_bm;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdata;

    logic          r1_valid;
    logic          r1_ready;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic [DW-1:0] r1_bm;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdata;

    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_bm;
    logic          sram_men;
    logic          sram_wen;
    logic          sram_ren;
    logic [DW-1:0] sram_dout;

    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata, r0_bm,
        output r0_ready, r0_rvalid, r0_rdata,
        input  r1_valid, r1_we, r1_addr, r1_wdata, r1_bm,
        output r1_ready, r1_rvalid, r1_rdata,
        output sram_addr, sram_din, sram_bm, sram_men, sram_wen, sram_ren,
        input  sram_dout
    );

    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata, r0_bm,
        input  r0_ready, r0_rvalid, r0_rdata,
        output r1_valid, r1_we, r1_addr, r1_wdata, r1_bm,
        input  r1_ready, r1_rvalid, r1_rdata,
        input  sram_addr, sram_din, sram_bm, sram_men, sram_wen, sram_ren,
        output sram_dout
    );
endinterface

// File: rtl/sram_arb2_ctrl.sv
// Two-port arbiter/sequencer for a single-port 1024x32 SRAM, fixed 3-cycle read latency.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0 wins).
module sram_arb2_ctrl #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    sram_arb2_ctrl_if.slave  bus
);
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_HOLD_OFF = 1'b1;

    logic [0:0]    state;
    logic          idle;
    logic          sel1;
    logic          ready0;
    logic          ready1;
    logic          hs;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] cmd_bm;

    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_bm;
    logic          sram_men;
    logic          sram_wen;
    logic          sram_ren;

    // vld_pipe[k]: a read accepted k cycles ago; own_pipe[k]: its requester (1 = port 1)
    logic [3:1]    vld_pipe;
    logic [3:1]    own_pipe;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;

`ifdef SRAM_ARB_RR_EN
    logic last1;
`endif

    always_comb begin
        idle = (state == ST_IDLE);
`ifdef SRAM_ARB_RR_EN
        sel1 = bus.r1_valid && (!bus.r0_valid || !last1);
`else
        sel1 = bus.r1_valid && !bus.r0_valid;
`endif
        ready0 = idle && !sel1;
        ready1 = idle && sel1;
        hs     = (bus.r0_valid && ready0) || (bus.r1_valid && ready1);
        if (sel1) begin
            cmd_we    = bus.r1_we;
            cmd_addr  = bus.r1_addr;
            cmd_wdata = bus.r1_wdata;
            cmd_bm    = bus.r1_bm;
        end else begin
            cmd_we    = bus.r0_we;
            cmd_addr  = bus.r0_addr;
            cmd_wdata = bus.r0_wdata;
            cmd_bm    = bus.r0_bm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_HOLD_OFF;
            sram_addr <= '0;
            sram_din  <= '0;
            sram_bm   <= '0;
            sram_men  <= 1'b0;
            sram_wen  <= 1'b0;
            sram_ren  <= 1'b0;
            vld_pipe  <= '0;
            own_pipe  <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state    <= ST_IDLE;
            sram_men <= hs;
            sram_wen <= hs && cmd_we;
            sram_ren <= hs && !cmd_we;
            // addr/din hold their last value on idle cycles
            if (hs) begin
                sram_addr <= cmd_addr;
                sram_bm   <= cmd_we ? cmd_bm : '1;
                if (cmd_we)
                    sram_din <= cmd_wdata;
            end
            vld_pipe <= {vld_pipe[2:1], hs && !cmd_we};
            own_pipe <= {own_pipe[2:1], sel1};
            if (vld_pipe[2]) begin
                if (own_pipe[2])
                    rdata1 <= bus.sram_dout;
                else
                    rdata0 <= bus.sram_dout;
            end
        end
    end

`ifdef SRAM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            last1 <= 1'b0;
        else if (hs)
            last1 <= sel1;
    end
`endif

    assign bus.r0_ready  = ready0;
    assign bus.r1_ready  = ready1;
    assign bus.r0_rvalid = vld_pipe[3] && !own_pipe[3];
    assign bus.r1_rvalid = vld_pipe[3] && own_pipe[3];
    assign bus.r0_rdata  = rdata0;
    assign bus.r1_rdata  = rdata1;
    assign bus.sram_addr = sram_addr;
    assign bus.sram_din  = sram_din;
    assign bus.sram_bm   = sram_bm;
    assign bus.sram_men  = sram_men;
    assign bus.sram_wen  = sram_wen;
    assign bus.sram_ren  = sram_ren;
endmodule

// File: tb/tb_sram_arb2_ctrl.sv
// Directed bench for sram_arb2_ctrl with a behavioural 1024x32 bit-masked SRAM model.
// Expectations follow SRAM_ARB_RR_EN the same way the design does.
module tb_sram_arb2_ctrl;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    sram_arb2_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    sram_arb2_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // SRAM model: write masked by bm, read data on DOUT the cycle after REN
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.sram_men === 1'b1) begin
            if (bus.sram_wen === 1'b1)
                mem[bus.sram_addr] <= (mem[bus.sram_addr] & ~bus.sram_bm) | (bus.sram_din & bus.sram_bm);
            if (bus.sram_ren === 1'b1)
                bus.sram_dout <= mem[bus.sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]    grants;
        logic [DW-1:0] exp_d;
        int            a;

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) mem['h100 + i] = 32'('h100 + i) ^ 32'hA5A5A5A5;
        bus.sram_dout = '0;
        bus.r0_valid = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0; bus.r0_bm = '0;
        bus.r1_valid = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0; bus.r1_bm = '0;

        // reset held 3 cycles with r0_valid high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_men", bus.sram_men, 0);
        chk("rst_wen", bus.sram_wen, 0);
        chk("rst_ren", bus.sram_ren, 0);
        chk("rst_addr", bus.sram_addr, 0);
        chk("rst_bm", bus.sram_bm, 0);
        chk("rst_din", bus.sram_din, 0);
        chk("rst_r0_ready", bus.r0_ready, 0);
        chk("rst_r1_ready", bus.r1_ready, 0);
        chk("rst_r0_rvalid", bus.r0_rvalid, 0);
        chk("rst_r1_rvalid", bus.r1_rvalid, 0);
        chk("rst_r0_rdata", bus.r0_rdata, 0);
        chk("rst_r1_rdata", bus.r1_rdata, 0);
        rst_n = 1'b1;
        #1;
        chk("holdoff_r0_ready", bus.r0_ready, 0);
        chk("holdoff_r1_ready", bus.r1_ready, 0);
        nxt();
        chk("post_holdoff_r0_ready", bus.r0_ready, 1);
        chk("post_holdoff_r1_ready", bus.r1_ready, 0);
        chk("holdoff_no_men", bus.sram_men, 0);
        bus.r0_valid = 1'b0;
        nxt();

        // write 0x005 then read it back on the next cycle
        bus.r0_valid = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 10'h005;
        bus.r0_wdata = 32'hDEADBEEF; bus.r0_bm = 32'hFFFFFFFF;
        #1 chk("wr_ready", bus.r0_ready, 1);
        nxt();
        chk("wr_t1_wen", bus.sram_wen, 1);
        chk("wr_t1_ren", bus.sram_ren, 0);
        chk("wr_t1_addr", bus.sram_addr, 10'h005);
        chk("wr_t1_din", bus.sram_din, 32'hDEADBEEF);
        bus.r0_we = 1'b0;
        #1 chk("rd_ready", bus.r0_ready, 1);
        nxt();
        bus.r0_valid = 1'b0;
        chk("rd_t2_ren", bus.sram_ren, 1);
        chk("rd_t2_wen", bus.sram_wen, 0);
        chk("rd_t2_bm", bus.sram_bm, 32'hFFFFFFFF);
        nxt();
        chk("rd_t3_rvalid", bus.r0_rvalid, 0);
        chk("rd_t3_men", bus.sram_men, 0);
        chk("rd_t3_addr_hold", bus.sram_addr, 10'h005);
        nxt();
        chk("rd_t4_rvalid", bus.r0_rvalid, 1);
        chk("rd_t4_rdata", bus.r0_rdata, 32'hDEADBEEF);
        chk("rd_t4_r1_rvalid", bus.r1_rvalid, 0);
        nxt();
        chk("rd_t5_rvalid", bus.r0_rvalid, 0);
        chk("rd_t5_rdata_hold", bus.r0_rdata, 32'hDEADBEEF);

        // partial write at the top address
        bus.r0_valid = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 10'h3FF;
        bus.r0_wdata = 32'hFFFFFFFF; bus.r0_bm = 32'hFFFFFFFF;
        nxt();
        bus.r0_wdata = 32'h00000000; bus.r0_bm = 32'h0000FFFF;
        nxt();
        bus.r0_we = 1'b0;
        nxt();
        bus.r0_valid = 1'b0;
        nxt();
        nxt();
        chk("pw_rvalid", bus.r0_rvalid, 1);
        chk("pw_rdata", bus.r0_rdata, 32'hFFFF0000);
        nxt();

        // 16 back-to-back reads by r1
        for (int k = 0; k < 20; k++) begin
            if (k < 16) begin
                bus.r1_valid = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = AW'('h100 + k);
            end else begin
                bus.r1_valid = 1'b0;
            end
            #1;
            if (k < 16) chk("b2b_ready", bus.r1_ready, 1);
            chk("b2b_rvalid", bus.r1_rvalid, (k >= 3 && k < 19) ? 1 : 0);
            chk("b2b_r0_rvalid", bus.r0_rvalid, 0);
            if (k >= 3 && k < 19) begin
                a = 'h100 + k - 3;
                exp_d = 32'(a) ^ 32'hA5A5A5A5;
                chk("b2b_rdata", bus.r1_rdata, exp_d);
            end
            nxt();
        end

        // both requesters valid for 4 cycles; last grant was port 1
`ifdef SRAM_ARB_RR_EN
        grants = 4'b1010;
`else
        grants = 4'b0000;
`endif
        bus.r0_valid = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 10'h010;
        bus.r1_valid = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 10'h020;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("arb_r0_ready", bus.r0_ready, grants[k] ? 0 : 1);
            chk("arb_r1_ready", bus.r1_ready, grants[k] ? 1 : 0);
            if (k > 0) chk("arb_addr", bus.sram_addr, grants[k-1] ? 10'h020 : 10'h010);
            nxt();
        end
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        chk("arb_addr_last", bus.sram_addr, grants[3] ? 10'h020 : 10'h010);
        repeat (4) nxt();

        // reset while an r1 read is in flight
        bus.r1_valid = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 10'h100;
        #1 chk("mid_ready", bus.r1_ready, 1);
        nxt();
        bus.r1_valid = 1'b0;
        chk("mid_ren", bus.sram_ren, 1);
        nxt();
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        chk("mid_rst_rvalid", bus.r1_rvalid, 0);
        chk("mid_rst_rdata", bus.r1_rdata, 0);
        chk("mid_rst_men", bus.sram_men, 0);
        #1 chk("mid_holdoff_r0_ready", bus.r0_ready, 0);
        nxt();
        chk("mid_t4_rvalid", bus.r1_rvalid, 0);
        chk("mid_t4_r0_ready", bus.r0_ready, 1);
        nxt();
        chk("mid_t5_rvalid", bus.r1_rvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
